// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load clamp helper for the BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register. It moves only when this is a step cycle and the
// carry/borrow chain reaches it; cout ripples on to the next digit.
import bcd_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic       step,
    input  logic       up_dn,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    assign cout = cin & (up_dn ? (q == BCD_MAX) : (q == BCD_MIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_clamp(load_d);
        end else if (step && cin) begin
            if (up_dn)
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            else
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with prescaler, load and wrap pulse.
// Define BCD_SATURATE_EN to hold at the terminal count instead of wrapping.
import bcd_pkg::*;

module bcd_counter_n #(
    parameter int NUM_DIGITS = 2,
    parameter int PRESCALE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       pre;
    logic                step_raw;
    logic                step_dig;
    logic                terminal;
    logic [NUM_DIGITS:0] carry;

    assign step_raw = en & ~load & (pre == PRE_LAST);
    assign carry[0] = step_raw;
    assign terminal = carry[NUM_DIGITS];

    // The carry chain always sees the raw step so the terminal flag stays
    // valid even when the digits themselves are held back.
`ifdef BCD_SATURATE_EN
    assign step_dig = step_raw & ~terminal;
`else
    assign step_dig = step_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            pre  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= terminal;
            if (en)
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .load_d (load_val[4*i +: 4]),
            .step   (step_dig),
            .up_dn  (up_dn),
            .cin    (carry[i]),
            .q      (count[4*i +: 4]),
            .cout   (carry[i+1])
        );
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: three instances cover 2-digit, 3-digit
// and prescaled configurations. Honours BCD_SATURATE_EN when defined.
module tb_bcd_counter_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en2 = 0, up2 = 1, ld2 = 0;
    logic [7:0]  lv2 = '0, cnt2;
    logic        wr2;
    logic        en3 = 0, up3 = 1, ld3 = 0;
    logic [11:0] lv3 = '0, cnt3;
    logic        wr3;
    logic        en4 = 0, up4 = 1, ld4 = 0;
    logic [7:0]  lv4 = '0, cnt4;
    logic        wr4;

    int total = 0;
    int bad   = 0;

    bcd_counter_n #(.NUM_DIGITS(2), .PRESCALE(1)) u_c2 (
        .clk(clk), .rst(rst), .en(en2), .up_dn(up2), .load(ld2),
        .load_val(lv2), .count(cnt2), .wrap(wr2));
    bcd_counter_n #(.NUM_DIGITS(3), .PRESCALE(1)) u_c3 (
        .clk(clk), .rst(rst), .en(en3), .up_dn(up3), .load(ld3),
        .load_val(lv3), .count(cnt3), .wrap(wr3));
    bcd_counter_n #(.NUM_DIGITS(2), .PRESCALE(4)) u_c4 (
        .clk(clk), .rst(rst), .en(en4), .up_dn(up4), .load(ld4),
        .load_val(lv4), .count(cnt4), .wrap(wr4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        // reset all instances
        rst = 1;
        tick();
        chk("rst_cnt2", 32'(cnt2), 32'h0);
        chk("rst_wr2", 32'(wr2), 32'h0);
        chk("rst_cnt3", 32'(cnt3), 32'h0);
        chk("rst_cnt4", 32'(cnt4), 32'h0);
        rst = 0;

        // 2-digit count up through 99 and back
        en2 = 1; up2 = 1;
        for (int i = 1; i <= 100; i++) begin
            tick();
`ifdef BCD_SATURATE_EN
            chk("up_cnt", 32'(cnt2), 32'(to_bcd2(i == 100 ? 99 : i)));
`else
            chk("up_cnt", 32'(cnt2), 32'(to_bcd2(i % 100)));
`endif
            chk("up_wrap", 32'(wr2), 32'(i == 100));
        end
        en2 = 0;
        tick();
        chk("up_wrap_clr", 32'(wr2), 32'h0);

        // 3-digit borrow across two digits
        en3 = 1; up3 = 0; ld3 = 1; lv3 = 12'h100;
        tick();
        chk("ld100", 32'(cnt3), 32'h100);
        chk("ld100_wrap", 32'(wr3), 32'h0);
        ld3 = 0;
        tick();
        chk("dn099", 32'(cnt3), 32'h099);
        chk("dn099_wrap", 32'(wr3), 32'h0);
        tick();
        chk("dn098", 32'(cnt3), 32'h098);
        chk("dn098_wrap", 32'(wr3), 32'h0);

        // per-digit clamp on load
        ld3 = 1; lv3 = 12'hAB5;
        tick();
        chk("clamp3", 32'(cnt3), 32'h995);

        // down terminal count from zero
        lv3 = 12'h000;
        tick();
        chk("ld000", 32'(cnt3), 32'h000);
        ld3 = 0;
        tick();
`ifdef BCD_SATURATE_EN
        chk("dn_term_cnt", 32'(cnt3), 32'h000);
        chk("dn_term_wrap", 32'(wr3), 32'h1);
        tick();
        chk("dn_term_cnt2", 32'(cnt3), 32'h000);
        chk("dn_term_wrap2", 32'(wr3), 32'h1);
`else
        chk("dn_term_cnt", 32'(cnt3), 32'h999);
        chk("dn_term_wrap", 32'(wr3), 32'h1);
        tick();
        chk("dn_term_cnt2", 32'(cnt3), 32'h998);
        chk("dn_term_wrap2", 32'(wr3), 32'h0);
`endif
        en3 = 0;
        tick();
        chk("dn_wrap_clr", 32'(wr3), 32'h0);

        // prescale by 4
        en4 = 1; up4 = 1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk("pre_cnt", 32'(cnt4), 32'(to_bcd2(t / 4)));
        end
        en4 = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("pre_hold", 32'(cnt4), 32'h02);
        end
        en4 = 1;
        tick();
        chk("pre_resume1", 32'(cnt4), 32'h02);
        tick();
        chk("pre_resume2", 32'(cnt4), 32'h02);
        tick();
        chk("pre_resume3", 32'(cnt4), 32'h03);

        // load on a step cycle wins and clears the prescaler
        tick();
        tick();
        tick();
        chk("pre_before_ld", 32'(cnt4), 32'h03);
        ld4 = 1; lv4 = 8'h3C;
        tick();
        chk("ld_step_cnt", 32'(cnt4), 32'h39);
        chk("ld_step_wrap", 32'(wr4), 32'h0);
        ld4 = 0;
        tick();
        tick();
        tick();
        chk("ld_pre_clr3", 32'(cnt4), 32'h39);
        tick();
        chk("ld_pre_clr4", 32'(cnt4), 32'h40);

        // reset mid-count discards progress
        ld4 = 1; lv4 = 8'h57;
        tick();
        chk("ld57", 32'(cnt4), 32'h57);
        ld4 = 0;
        tick();
        rst = 1;
        tick();
        chk("rst_mid_cnt", 32'(cnt4), 32'h00);
        chk("rst_mid_wrap", 32'(wr4), 32'h0);
        rst = 0;
        tick();
        tick();
        tick();
        chk("post_rst3", 32'(cnt4), 32'h00);
        tick();
        chk("post_rst4", 32'(cnt4), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
